cordic_iter_core: RTL and testbench

//  Iterative, multi-mode CORDIC core. It performs one micro-rotation per clock and supports both

---
 rtl/cordic_iter_core.sv | 137 +++++++++++++
 tb/tb_cordic_iter_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core: one micro-rotation per clock in rotation or vectoring mode,
// valid/ready on both sides, arctangent table built at elaboration.
module cordic_iter_core #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH+1:0] x_in,
  input  logic signed [WIDTH+1:0] y_in,
  input  logic signed [WIDTH+1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic signed [WIDTH+1:0] z_out
);
  localparam int DW        = WIDTH + 2;
  localparam int CW        = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int MAX_ITERS = (DW < 32) ? DW : 32;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  if (ITERS < 1 || ITERS > MAX_ITERS) begin : g_bad_iters
    $error("cordic_iter_core: ITERS=%0d outside 1..%0d", ITERS, MAX_ITERS);
  end

  // atan(2^-i) in radians; beyond i=12 the odd-power series is exact to double precision.
  function automatic logic signed [DW-1:0] atan_q(input int i);
    real a;
    real t;
    t = 2.0 ** (-i);
    case (i)
      0:  a = 0.7853981633974483;
      1:  a = 0.4636476090008061;
      2:  a = 0.24497866312686414;
      3:  a = 0.12435499454676144;
      4:  a = 0.06241880999595735;
      5:  a = 0.031239833430268277;
      6:  a = 0.015623728620476831;
      7:  a = 0.007812341060101111;
      8:  a = 0.0039062301319669718;
      9:  a = 0.0019531225164788188;
      10: a = 0.0009765621895593195;
      11: a = 0.0004882812111948983;
      12: a = 0.00024414062014936177;
      default: a = t - (t * t * t) / 3.0 + (t * t * t * t * t) / 5.0;
    endcase
    return DW'(longint'(a * (2.0 ** WIDTH)));
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic signed [DW-1:0] x_q, y_q, z_q;
  logic signed [DW-1:0] x_d, y_d, z_d;
  logic signed [DW-1:0] x_sh, y_sh, atan_i;
  logic                 d_pos;
  logic signed [DW-1:0] atan_tab [2**CW];

  for (genvar g = 0; g < 2**CW; g++) begin : g_atan
    localparam logic signed [DW-1:0] ATAN_G = atan_q(g);
    assign atan_tab[g] = ATAN_G;
  end

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_tab[cnt_q];
  // Rotation steers z toward 0, vectoring steers y toward 0.
  assign d_pos  = mode_q ? y_q[DW-1] : ~z_q[DW-1];

  assign in_ready  = (state_q == IDLE) && reset_n;
  assign out_valid = (state_q == DONE);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mode_d  = in_mode;
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (d_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_cordic_iter_core.sv
// Bench for cordic_iter_core: directed trig vectors, random operands against a
// reference built from the CORDIC equations with a runtime atan, plus handshake/reset scenarios.
module tb_cordic_iter_core;
  localparam int W  = 16;
  localparam int IT = 16;
  localparam int DW = W + 2;

  logic                 clk;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic signed [DW-1:0] x_in, y_in, z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_out, y_out, z_out;

  int n_cmp;
  int n_fail;
  int cyc;

  cordic_iter_core #(.WIDTH(W), .ITERS(IT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: ITERS micro-rotations from the update equations, angles from $atan.
  function automatic void cordic_ref(input logic m, input logic signed [DW-1:0] xi, yi, zi,
                                     output logic signed [DW-1:0] xo, yo, zo);
    logic signed [DW-1:0] x, y, z, xn, yn, at;
    logic up;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < IT; i++) begin
      at = DW'(longint'($atan(2.0 ** (-i)) * (2.0 ** W)));
      up = m ? (y < 0) : (z >= 0);
      if (up) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - at;
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + at;
      end
      x = xn; y = yn;
    end
    xo = x; yo = y; zo = z;
  endfunction

  function automatic logic signed [DW-1:0] rnd(input int mag);
    return DW'(int'($urandom_range(0, 2 * mag)) - mag);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One operation with out_ready=1; in_valid stays high with junk operands while busy.
  task automatic run_op(input logic m, input logic signed [DW-1:0] xi, yi, zi,
                        output logic signed [DW-1:0] xr, yr, zr);
    int lat;
    int t;
    @(negedge clk);
    in_mode = m; x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1; out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL op_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_mode = ~m; x_in = ~xi; y_in = ~yi; z_in = zi + 18'sd1000;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    xr = x_out; yr = y_out; zr = z_out;
    n_cmp++;
    if (lat !== IT) begin
      n_fail++; $display("FAIL op_latency: cycles=%0d required %0d", lat, IT);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL op_release: out_valid,in_ready=%b%b required 01", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl: in_ready,out_valid=%b%b required 00", in_ready, out_valid);
    end
    n_cmp++;
    if ({x_out, y_out, z_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: x=%0d y=%0d z=%0d required 0", x_out, y_out, z_out);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: in_ready,out_valid=%b%b required 10", in_ready, out_valid);
    end
  endtask

  task automatic test_directed(input logic m, input int xi, yi, zi, input int ex, ey, ez,
                               input string name);
    logic signed [DW-1:0] xr, yr, zr, mx, my, mz;
    run_op(m, DW'(xi), DW'(yi), DW'(zi), xr, yr, zr);
    cordic_ref(m, DW'(xi), DW'(yi), DW'(zi), mx, my, mz);
    n_cmp++;
    if (iabs(int'(xr) - ex) > 4 || iabs(int'(yr) - ey) > 4 || iabs(int'(zr) - ez) > 4) begin
      n_fail++;
      $display("FAIL %s_approx: got x=%0d y=%0d z=%0d required %0d %0d %0d (+/-4)",
               name, xr, yr, zr, ex, ey, ez);
    end
    n_cmp++;
    if ({xr, yr, zr} !== {mx, my, mz}) begin
      n_fail++;
      $display("FAIL %s_exact: got x=%0d y=%0d z=%0d required %0d %0d %0d", name, xr, yr, zr, mx, my, mz);
    end
  endtask

  task automatic test_random();
    logic signed [DW-1:0] xi, yi, zi, xr, yr, zr, mx, my, mz;
    logic m;
    for (int k = 0; k < 12; k++) begin
      m  = k[0];
      xi = rnd(55705);
      yi = rnd(55705);
      zi = m ? rnd(32768) : rnd(114032);
      run_op(m, xi, yi, zi, xr, yr, zr);
      cordic_ref(m, xi, yi, zi, mx, my, mz);
      n_cmp++;
      if ({xr, yr, zr} !== {mx, my, mz}) begin
        n_fail++;
        $display("FAIL random_%0d: mode=%b got x=%0d y=%0d z=%0d required %0d %0d %0d",
                 k, m, xr, yr, zr, mx, my, mz);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] hx, hy, hz, mx, my, mz;
    int t;
    @(negedge clk);
    in_mode = 1'b0; x_in = 18'sd30000; y_in = -18'sd20000; z_in = 18'sd40000;
    in_valid = 1'b1; out_ready = 1'b0;
    cordic_ref(1'b0, 18'sd30000, -18'sd20000, 18'sd40000, mx, my, mz);
    @(posedge clk); #1;
    t = 0;
    while (!out_valid && t < 100) begin
      x_in = rnd(50000); y_in = rnd(50000); z_in = rnd(50000);
      @(posedge clk); #1;
      t++;
    end
    hx = x_out; hy = y_out; hz = z_out;
    n_cmp++;
    if ({out_valid, hx, hy, hz} !== {1'b1, mx, my, mz}) begin
      n_fail++;
      $display("FAIL bp_result: valid=%b x=%0d y=%0d z=%0d required 1 %0d %0d %0d",
               out_valid, hx, hy, hz, mx, my, mz);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_mode = c[0]; x_in = rnd(50000); y_in = rnd(50000); z_in = rnd(50000);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, x_out, y_out, z_out} !== {2'b10, hx, hy, hz}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b x=%0d y=%0d z=%0d required 1 0 %0d %0d %0d",
                 c, out_valid, in_ready, x_out, y_out, z_out, hx, hy, hz);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: out_valid,in_ready=%b%b required 01", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] ox [4], oy [4], oz [4];
    logic                 om [4];
    logic signed [DW-1:0] eq_x [$], eq_y [$], eq_z [$];
    logic signed [DW-1:0] mx, my, mz, ex, ey, ez;
    int acc_cyc [4];
    int n_acc, n_res, t;
    logic acc, hs;
    for (int k = 0; k < 4; k++) begin
      om[k] = ($urandom_range(0, 1) == 1);
      ox[k] = rnd(55705); oy[k] = rnd(55705); oz[k] = om[k] ? rnd(20000) : rnd(100000);
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    in_mode = om[0]; x_in = ox[0]; y_in = oy[0]; z_in = oz[0];
    n_acc = 0; n_res = 0; t = 0;
    while (n_res < 4 && t < 200) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (acc) acc_cyc[n_acc] = cyc;
      if (hs) begin
        ex = eq_x.size() > 0 ? eq_x.pop_front() : '0;
        ey = eq_y.size() > 0 ? eq_y.pop_front() : '0;
        ez = eq_z.size() > 0 ? eq_z.pop_front() : '0;
        n_cmp++;
        if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: x=%0d y=%0d z=%0d required %0d %0d %0d",
                   n_res, x_out, y_out, z_out, ex, ey, ez);
        end
        n_res++;
      end
      @(posedge clk); #1;
      if (acc) begin
        cordic_ref(om[n_acc], ox[n_acc], oy[n_acc], oz[n_acc], mx, my, mz);
        eq_x.push_back(mx); eq_y.push_back(my); eq_z.push_back(mz);
        n_acc++;
        if (n_acc < 4) begin
          in_mode = om[n_acc]; x_in = ox[n_acc]; y_in = oy[n_acc]; z_in = oz[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (n_res !== 4 || n_acc !== 4) begin
      n_fail++; $display("FAIL b2b_count: accepts=%0d results=%0d required 4 4", n_acc, n_res);
    end
    for (int k = 1; k < n_acc; k++) begin
      n_cmp++;
      if (acc_cyc[k] - acc_cyc[k-1] !== IT + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing_%0d: cycles=%0d required %0d", k, acc_cyc[k] - acc_cyc[k-1], IT + 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic signed [DW-1:0] xr, yr, zr, mx, my, mz;
    logic seen;
    @(negedge clk);
    in_mode = 1'b0; x_in = 18'sd39797; y_in = '0; z_in = 18'sd51472;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, x_out, y_out, z_out} !== {2'b00, {(3*DW){1'b0}}}) begin
      n_fail++;
      $display("FAIL midrst_state: valid=%b ready=%b x=%0d y=%0d z=%0d required 0 0 0 0 0",
               out_valid, in_ready, x_out, y_out, z_out);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: in_ready=%b required 1", in_ready);
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_valid: out_valid seen=%b required 0", seen);
    end
    run_op(1'b1, 18'sd40000, -18'sd25000, 18'sd1000, xr, yr, zr);
    cordic_ref(1'b1, 18'sd40000, -18'sd25000, 18'sd1000, mx, my, mz);
    n_cmp++;
    if ({xr, yr, zr} !== {mx, my, mz}) begin
      n_fail++;
      $display("FAIL midrst_next_op: x=%0d y=%0d z=%0d required %0d %0d %0d", xr, yr, zr, mx, my, mz);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed(1'b0, 39797, 0, 51472, 46341, 46341, 0, "rot_pi4");
    test_directed(1'b0, 39797, 0, -34315, 56756, -32768, 0, "rot_neg_pi6");
    test_directed(1'b1, 32768, 32768, 0, 76313, 0, 51472, "vec_45");
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
